// File: rtl/ibex_rvfi_trace_buf.sv
// Retirement-trace capture buffer: packs RVFI retirements into a circular buffer and drains them in order.
// Define IBEX_RVFI_TRACE_TIMESTAMP_EN to prepend a 32-bit cycle timestamp to every record.
//   state    | meaning
//   S_RUN    | retirements are captured
//   S_FROZEN | a trap was captured with freeze enabled; pushes ignored, drain continues
module ibex_rvfi_trace_buf #(
    parameter int unsigned NumRet   = 1,
    parameter int unsigned Depth    = 16,
    parameter int unsigned DropCntW = 16,
`ifdef IBEX_RVFI_TRACE_TIMESTAMP_EN
    parameter int unsigned RecW     = 150,
`else
    parameter int unsigned RecW     = 118,
`endif
    parameter int unsigned AW       = $clog2(Depth),
    parameter int unsigned PtrW     = AW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumRet-1:0]      rvfi_valid_i,
    input  logic [NumRet*64-1:0]   rvfi_order_i,
    input  logic [NumRet*32-1:0]   rvfi_pc_i,
    input  logic [NumRet*32-1:0]   rvfi_insn_i,
    input  logic [NumRet-1:0]      rvfi_trap_i,
    input  logic [NumRet*5-1:0]    rvfi_rd_addr_i,
    input  logic [NumRet*32-1:0]   rvfi_rd_wdata_i,
    input  logic                   freeze_on_trap_i,
    input  logic                   clear_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [RecW-1:0]        out_rec_o,
    output logic [PtrW-1:0]        level_o,
    output logic [DropCntW-1:0]    drop_cnt_o,
    output logic                   order_err_o,
    output logic                   frozen_o
);

    typedef enum logic {S_RUN, S_FROZEN} state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DropCntW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [63:0]           exp_q, exp_d;
    logic                  expv_q, expv_d;
    logic                  err_q, err_d;
    logic [RecW-1:0]       mem_q [Depth];

    logic [PtrW-1:0]       level, free_slots, push_cnt;
    logic                  pop, freeze_hit, stop;
    logic [1:0]            drop_n;
    logic [DropCntW:0]     drop_sum;
    logic [NumRet-1:0]     wr_en;
    logic [AW-1:0]         wr_idx   [NumRet];
    logic [RecW-1:0]       lane_rec [NumRet];
    logic [31:0]           ts_val;

`ifdef IBEX_RVFI_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      ts_q <= '0;
        else if (clear_i) ts_q <= '0;
        else              ts_q <= ts_q + 32'd1;
    end
    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    assign level      = wptr_q - rptr_q;
    assign pop        = (level != '0) && out_ready_i;
    // A same-cycle pop frees its slot before the pushes are placed.
    assign free_slots = PtrW'(Depth) - level + {{AW{1'b0}}, pop};

    always_comb begin
        push_cnt   = '0;
        drop_n     = '0;
        freeze_hit = 1'b0;
        stop       = 1'b0;
        exp_d      = exp_q;
        expv_d     = expv_q;
        err_d      = err_q;
        for (int l = 0; l < NumRet; l++) begin
            wr_en[l]    = 1'b0;
            wr_idx[l]   = '0;
`ifdef IBEX_RVFI_TRACE_TIMESTAMP_EN
            lane_rec[l] = {ts_val, rvfi_trap_i[l], rvfi_rd_addr_i[l*5 +: 5], rvfi_order_i[l*64 +: 16],
                           rvfi_pc_i[l*32 +: 32], rvfi_insn_i[l*32 +: 32], rvfi_rd_wdata_i[l*32 +: 32]};
`else
            lane_rec[l] = {rvfi_trap_i[l], rvfi_rd_addr_i[l*5 +: 5], rvfi_order_i[l*64 +: 16],
                           rvfi_pc_i[l*32 +: 32], rvfi_insn_i[l*32 +: 32], rvfi_rd_wdata_i[l*32 +: 32]};
`endif
            if (rvfi_valid_i[l] && (state_q == S_RUN) && !stop) begin
                if (expv_d && (rvfi_order_i[l*64 +: 64] != exp_d)) err_d = 1'b1;
                exp_d  = rvfi_order_i[l*64 +: 64] + 64'd1;
                expv_d = 1'b1;
                if (push_cnt < free_slots) begin
                    wr_en[l]  = 1'b1;
                    wr_idx[l] = wptr_q[AW-1:0] + push_cnt[AW-1:0];
                    push_cnt  = push_cnt + {{AW{1'b0}}, 1'b1};
                    if (freeze_on_trap_i && rvfi_trap_i[l]) begin
                        freeze_hit = 1'b1;
                        stop       = 1'b1;
                    end
                end else begin
                    drop_n = drop_n + 2'd1;
                end
            end
        end
        wptr_d     = wptr_q + push_cnt;
        rptr_d     = rptr_q + {{AW{1'b0}}, pop};
        drop_sum   = {1'b0, drop_cnt_q} + {{(DropCntW-1){1'b0}}, drop_n};
        drop_cnt_d = drop_sum[DropCntW] ? {DropCntW{1'b1}} : drop_sum[DropCntW-1:0];
    end

    always_comb begin
        state_d = state_q;
        if (clear_i)         state_d = S_RUN;
        else if (freeze_hit) state_d = S_FROZEN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_RUN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            drop_cnt_q <= '0;
            exp_q      <= '0;
            expv_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (clear_i) begin
            state_q    <= state_d;
            wptr_q     <= '0;
            rptr_q     <= '0;
            drop_cnt_q <= '0;
            exp_q      <= '0;
            expv_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            drop_cnt_q <= drop_cnt_d;
            exp_q      <= exp_d;
            expv_q     <= expv_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NumRet; l++) begin
            if (wr_en[l]) mem_q[wr_idx[l]] <= lane_rec[l];
        end
    end

    assign out_valid_o = (level != '0);
    assign out_rec_o   = mem_q[rptr_q[AW-1:0]];
    assign level_o     = level;
    assign drop_cnt_o  = drop_cnt_q;
    assign order_err_o = err_q;
    assign frozen_o    = (state_q == S_FROZEN);

endmodule
